// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: issue, write-back, MDU and register-file write port signals
interface wb_port_scheduler_if;
  logic        iss_valid;
  logic [4:0]  iss_src1;
  logic [4:0]  iss_src2;
  logic [4:0]  iss_dest;
  logic        iss_we;
  logic        iss_long;
  logic        iss_stall;
  logic        pipe_we;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_val;
  logic        wb_hold;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_val;
  logic        mdu_ready;
  logic        wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_val;
  logic [31:0] busy_vec;
  logic [3:0]  out_cnt;
  modport master (
    output iss_valid, iss_src1, iss_src2, iss_dest, iss_we, iss_long,
    output pipe_we, pipe_dest, pipe_val, mdu_valid, mdu_dest, mdu_val,
    input  iss_stall, wb_hold, mdu_ready, wr_en, wr_dest, wr_val, busy_vec, out_cnt
  );
  modport slave (
    input  iss_valid, iss_src1, iss_src2, iss_dest, iss_we, iss_long,
    input  pipe_we, pipe_dest, pipe_val, mdu_valid, mdu_dest, mdu_val,
    output iss_stall, wb_hold, mdu_ready, wr_en, wr_dest, wr_val, busy_vec, out_cnt
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: register-file write port arbiter (WB vs MDU) with busy-bit scoreboard
module wb_port_scheduler #(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic                clk,
  input logic                rst,
  wb_port_scheduler_if.slave bus
);
  typedef enum logic {ARB, HOLD} state_t;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t        state;
  logic [SW-1:0] starve;
  logic [31:0]   busy, busy_nxt;
  logic [3:0]    cnt;
  logic          hold, pipe_eff, grant, hazard, set_b, dec;
  always_comb begin
    pipe_eff      = bus.pipe_we & ~hold;
    grant         = ~pipe_eff & bus.mdu_valid;
    bus.mdu_ready = grant;
    bus.wr_en     = pipe_eff ? |bus.pipe_dest : grant & |bus.mdu_dest;
    bus.wr_dest   = pipe_eff ? bus.pipe_dest : grant ? bus.mdu_dest : 5'd0;
    bus.wr_val    = pipe_eff ? bus.pipe_val : grant ? bus.mdu_val : 32'd0;
    // busy[0] is never set, so $zero can never raise a hazard
    hazard        = busy[bus.iss_src1] | busy[bus.iss_src2] | (bus.iss_we & busy[bus.iss_dest])
                  | (bus.iss_long & (cnt == 4'(MAX_OUT)));
    bus.iss_stall = bus.iss_valid & hazard;
    set_b         = bus.iss_valid & ~hazard & bus.iss_long & bus.iss_we & |bus.iss_dest;
    dec           = grant & |cnt;
    busy_nxt      = busy;
    if (grant) busy_nxt[bus.mdu_dest] = 1'b0;
    if (set_b) busy_nxt[bus.iss_dest] = 1'b1;
    busy_nxt[0]   = 1'b0;
  end
  assign bus.busy_vec = busy;
  assign bus.out_cnt  = cnt;
  assign bus.wb_hold  = hold;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ARB;
      starve <= '0;
      hold   <= 1'b0;
      busy   <= '0;
      cnt    <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt + {3'b0, set_b} - {3'b0, dec};
      if (state == HOLD) begin
        state  <= ARB;
        starve <= '0;
        hold   <= 1'b0;
      end else if (bus.mdu_valid & pipe_eff) begin
        if (starve == SW'(STARVE_LIMIT - 1)) begin
          state  <= HOLD;
          hold   <= 1'b1;
          starve <= '0;
        end else begin
          starve <= starve + 1'b1;
        end
      end else begin
        starve <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed + random stimulus against an array-based scoreboard model
module tb_wb_port_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;

  wb_port_scheduler_if bus ();
  wb_port_scheduler #(.MAX_OUT(4), .STARVE_LIMIT(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.iss_valid = 0; bus.iss_src1 = 0; bus.iss_src2 = 0; bus.iss_dest = 0;
    bus.iss_we = 0; bus.iss_long = 0;
    bus.pipe_we = 0; bus.pipe_dest = 0; bus.pipe_val = 0;
    bus.mdu_valid = 0; bus.mdu_dest = 0; bus.mdu_val = 0;
  endtask

  task automatic rnd;
    bus.iss_valid = 1'($urandom_range(0, 1));
    bus.iss_src1  = 5'($urandom_range(0, 7));
    bus.iss_src2  = 5'($urandom_range(0, 7));
    bus.iss_dest  = 5'($urandom_range(0, 7));
    bus.iss_we    = 1'($urandom_range(0, 3) != 0);
    bus.iss_long  = 1'($urandom_range(0, 1));
    bus.pipe_we   = 1'($urandom_range(0, 1));
    bus.pipe_dest = 5'($urandom_range(0, 7));
    bus.pipe_val  = $urandom;
    bus.mdu_valid = 1'($urandom_range(0, 2) == 0);
    bus.mdu_dest  = 5'($urandom_range(0, 7));
    bus.mdu_val   = $urandom;
  endtask

  task automatic issue(input logic [4:0] d, input logic lng);
    bus.iss_valid = 1; bus.iss_src1 = 0; bus.iss_src2 = 0;
    bus.iss_dest = d; bus.iss_we = 1; bus.iss_long = lng;
  endtask

  task automatic retire(input logic [4:0] d, input logic [31:0] v);
    bus.mdu_valid = 1; bus.mdu_dest = d; bus.mdu_val = v;
  endtask

  // Reference model: per-register pending flags, outstanding count, run of consecutive MDU denials
  bit m_busy [32];
  int m_cnt, m_run;
  bit m_hold, m_ok;

  always @(negedge clk) begin : model
    bit pe, gr, st;
    logic [31:0] bv;
    pe = bus.pipe_we && !m_hold;
    gr = !pe && bus.mdu_valid;
    st = bus.iss_valid && ((bus.iss_src1 != 0 && m_busy[bus.iss_src1]) ||
                           (bus.iss_src2 != 0 && m_busy[bus.iss_src2]) ||
                           (bus.iss_we && bus.iss_dest != 0 && m_busy[bus.iss_dest]) ||
                           (bus.iss_long && m_cnt == 4));
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    if (m_ok) begin
      chk("iss_stall", 32'(bus.iss_stall), 32'(st));
      chk("mdu_ready", 32'(bus.mdu_ready), 32'(gr));
      chk("wr_en", 32'(bus.wr_en), pe ? 32'(bus.pipe_dest != 0) : 32'(gr && bus.mdu_dest != 0));
      chk("wr_dest", 32'(bus.wr_dest), pe ? 32'(bus.pipe_dest) : gr ? 32'(bus.mdu_dest) : 0);
      chk("wr_val", bus.wr_val, pe ? bus.pipe_val : gr ? bus.mdu_val : 0);
      chk("wb_hold", 32'(bus.wb_hold), 32'(m_hold));
      chk("busy_vec", bus.busy_vec, bv);
      chk("out_cnt", 32'(bus.out_cnt), m_cnt);
    end
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_cnt = 0; m_run = 0; m_hold = 0; m_ok = 1;
    end else if (m_ok) begin
      if (gr) begin
        m_busy[bus.mdu_dest] = 0;
        if (m_cnt > 0) m_cnt--;
      end
      if (bus.iss_valid && !st && bus.iss_long && bus.iss_we && bus.iss_dest != 0) begin
        m_busy[bus.iss_dest] = 1;
        m_cnt++;
      end
      if (m_hold) begin
        m_hold = 0; m_run = 0;
      end else if (bus.mdu_valid && pe) begin
        m_run++;
        if (m_run == 3) begin m_hold = 1; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end
  end

  initial begin
    rst = 0; rnd(); nxt(); rnd(); nxt();
    rst = 1; idle();
    bus.pipe_we = 1; bus.pipe_dest = 5; bus.pipe_val = 32'hA5;
    @(negedge clk);
    chk("rst busy_vec", bus.busy_vec, 0);
    chk("rst out_cnt", 32'(bus.out_cnt), 0);
    chk("rst wb_hold", 32'(bus.wb_hold), 0);
    chk("first wr_en", 32'(bus.wr_en), 1);
    chk("first wr_dest", 32'(bus.wr_dest), 5);
    chk("first wr_val", bus.wr_val, 32'hA5);
    nxt(); idle(); issue(8, 1);
    @(negedge clk); chk("raw issue stall", 32'(bus.iss_stall), 0);
    nxt(); idle(); bus.iss_valid = 1; bus.iss_src1 = 8;
    @(negedge clk);
    chk("raw busy_vec", bus.busy_vec, 32'h100);
    chk("raw out_cnt", 32'(bus.out_cnt), 1);
    chk("raw stall", 32'(bus.iss_stall), 1);
    nxt(); idle(); retire(8, 32'h1234);
    @(negedge clk);
    chk("raw wr_en", 32'(bus.wr_en), 1);
    chk("raw wr_dest", 32'(bus.wr_dest), 8);
    chk("raw wr_val", bus.wr_val, 32'h1234);
    chk("raw mdu_ready", 32'(bus.mdu_ready), 1);
    nxt(); idle(); bus.iss_valid = 1; bus.iss_src1 = 8;
    @(negedge clk);
    chk("raw cleared busy", bus.busy_vec, 0);
    chk("raw cleared stall", 32'(bus.iss_stall), 0);
    nxt(); idle();
    bus.pipe_we = 1; bus.pipe_dest = 3; bus.pipe_val = 32'h33; retire(10, 32'hBEEF);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("starve denied", 32'(bus.mdu_ready), 0);
      chk("starve no hold", 32'(bus.wb_hold), 0);
      nxt();
    end
    @(negedge clk);
    chk("starve hold", 32'(bus.wb_hold), 1);
    chk("starve hold dest", 32'(bus.wr_dest), 10);
    chk("starve hold ready", 32'(bus.mdu_ready), 1);
    nxt();
    @(negedge clk);
    chk("starve release", 32'(bus.wb_hold), 0);
    chk("starve pipe dest", 32'(bus.wr_dest), 3);
    chk("starve pipe ready", 32'(bus.mdu_ready), 0);
    for (int r = 1; r <= 4; r++) begin
      nxt(); idle(); issue(5'(r), 1);
      @(negedge clk); chk("cap fill stall", 32'(bus.iss_stall), 0);
    end
    nxt(); idle(); issue(9, 1);
    @(negedge clk);
    chk("cap out_cnt", 32'(bus.out_cnt), 4);
    chk("cap full stall", 32'(bus.iss_stall), 1);
    nxt(); retire(1, 32'h11);
    @(negedge clk); chk("cap retire ready", 32'(bus.mdu_ready), 1);
    nxt(); bus.mdu_valid = 0;
    @(negedge clk);
    chk("cap freed cnt", 32'(bus.out_cnt), 3);
    chk("cap freed stall", 32'(bus.iss_stall), 0);
    nxt(); idle();
    @(negedge clk); chk("cap busy_vec", bus.busy_vec, 32'h21C);
    foreach (m_busy[k]) if (k == 2 || k == 3 || k == 4 || k == 9) begin
      nxt(); idle(); retire(5'(k), 32'(k));
    end
    nxt(); idle();
    bus.pipe_we = 1; bus.pipe_dest = 0; bus.pipe_val = 32'hDEAD; issue(0, 1);
    @(negedge clk);
    chk("zero pre cnt", 32'(bus.out_cnt), 0);
    chk("zero wr_en", 32'(bus.wr_en), 0);
    chk("zero stall", 32'(bus.iss_stall), 0);
    nxt(); idle(); issue(7, 1);
    @(negedge clk);
    chk("zero busy_vec", bus.busy_vec, 0);
    chk("zero out_cnt", 32'(bus.out_cnt), 0);
    nxt(); idle(); issue(6, 1); retire(6, 32'h66);
    @(negedge clk);
    chk("sim stall", 32'(bus.iss_stall), 0);
    chk("sim ready", 32'(bus.mdu_ready), 1);
    nxt(); idle();
    @(negedge clk);
    chk("sim busy_vec", bus.busy_vec, 32'hC0);
    chk("sim out_cnt", 32'(bus.out_cnt), 1);
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rnd();
      rst = ($urandom_range(0, 149) != 0);
    end
    nxt(); idle(); rst = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
